// File: rtl/sif_rndsat_bfe_fixedp.sv
// Butterfly post-stage: round/shift/saturate the widened sum, present it on valid/ready via a 2-entry skid buffer.
// Latency 1 cycle; I_rdy is registered and drops only while both entries are held. Optional macro: SIF_RNDSAT_SAT_CNT_EN.
module sif_rndsat_bfe_fixedp #(
    parameter int WIDTH_I  = 17,
    parameter int WIDTH_O  = 16,
    parameter int SHIFT    = 1,
    parameter int RND_MODE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               I_vld,
    input  logic [WIDTH_I-1:0] I_dat,
    output logic               I_rdy,
    output logic               O_vld,
    output logic [WIDTH_O-1:0] O_dat,
    output logic               O_sat,
    input  logic               O_rdy
`ifdef SIF_RNDSAT_SAT_CNT_EN
    ,
    output logic [15:0]        sat_cnt
`endif
);

    localparam int WE  = WIDTH_I + 1;
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [WE-1:0] RND_ADD =
        (RND_MODE == 1 && SHIFT > 0) ? WE'(longint'(1) << RSH) : '0;
    localparam logic signed [WE-1:0] MAX_V = WE'((longint'(1) << (WIDTH_O - 1)) - 1);
    localparam logic signed [WE-1:0] MIN_V = ~MAX_V;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

    state_t               state_q, state_d;
    logic [WIDTH_O-1:0]   main_dat_q, main_dat_d, skid_dat_q, skid_dat_d;
    logic                 main_sat_q, main_sat_d, skid_sat_q, skid_sat_d;
    logic                 i_rdy_q, i_rdy_d;

    logic signed [WE-1:0] ext_s, sum_s, shf_s;
    logic [WIDTH_O-1:0]   new_dat;
    logic                 new_sat;
    logic                 in_xfer, out_xfer;

    // One guard bit above the input keeps the rounding add from wrapping.
    always_comb begin
        ext_s   = {I_dat[WIDTH_I-1], I_dat};
        sum_s   = ext_s + RND_ADD;
        shf_s   = sum_s >>> SHIFT;
        new_dat = shf_s[WIDTH_O-1:0];
        new_sat = 1'b0;
        if (shf_s > MAX_V) begin
            new_dat = MAX_V[WIDTH_O-1:0];
            new_sat = 1'b1;
        end else if (shf_s < MIN_V) begin
            new_dat = MIN_V[WIDTH_O-1:0];
            new_sat = 1'b1;
        end
    end

    assign in_xfer  = I_vld & i_rdy_q;
    assign out_xfer = O_vld & O_rdy;

    always_comb begin
        state_d    = state_q;
        main_dat_d = main_dat_q;
        main_sat_d = main_sat_q;
        skid_dat_d = skid_dat_q;
        skid_sat_d = skid_sat_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    main_dat_d = new_dat;
                    main_sat_d = new_sat;
                    state_d    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_xfer && !out_xfer) begin
                    skid_dat_d = new_dat;
                    skid_sat_d = new_sat;
                    state_d    = ST_FULL;
                end else if (in_xfer && out_xfer) begin
                    main_dat_d = new_dat;
                    main_sat_d = new_sat;
                end else if (out_xfer) begin
                    state_d    = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_xfer) begin
                    main_dat_d = skid_dat_q;
                    main_sat_d = skid_sat_q;
                    state_d    = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        i_rdy_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            main_dat_q <= '0;
            main_sat_q <= 1'b0;
            skid_dat_q <= '0;
            skid_sat_q <= 1'b0;
            i_rdy_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_dat_q <= main_dat_d;
            main_sat_q <= main_sat_d;
            skid_dat_q <= skid_dat_d;
            skid_sat_q <= skid_sat_d;
            i_rdy_q    <= i_rdy_d;
        end
    end

    assign I_rdy = i_rdy_q;
    assign O_vld = (state_q != ST_EMPTY);
    assign O_dat = main_dat_q;
    assign O_sat = main_sat_q;

`ifdef SIF_RNDSAT_SAT_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Counts delivered clipped samples, sticking at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (out_xfer && main_sat_q && (cnt_q != 16'hFFFF))
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign sat_cnt = cnt_q;
`endif

endmodule
